// File: rtl/nes_controller_port_pkg.sv
// nes_pkg: shared constants for the NES standard-controller port.
//   - button bit positions (same order in buttons, shift register, debug out)
//   - USB HID usage codes mapped onto each button
//   - CPU register addresses of the two controller ports
package nes_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [7:0] KEY_A_BTN      = 8'h0E; // K
  localparam logic [7:0] KEY_B_BTN      = 8'h0D; // J
  localparam logic [7:0] KEY_SELECT_BTN = 8'h2B; // Tab
  localparam logic [7:0] KEY_START_BTN  = 8'h28; // Enter
  localparam logic [7:0] KEY_UP_BTN     = 8'h1A; // W
  localparam logic [7:0] KEY_DOWN_BTN   = 8'h16; // S
  localparam logic [7:0] KEY_LEFT_BTN   = 8'h04; // A
  localparam logic [7:0] KEY_RIGHT_BTN  = 8'h07; // D

  localparam logic [15:0] JOY1_ADDR = 16'h4016;
  localparam logic [15:0] JOY2_ADDR = 16'h4017;

  // Kind of CPU access seen this cycle, as far as this block cares.
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_RD_JOY1,
    ACC_RD_JOY2,
    ACC_WR_JOY1
  } access_e;

  function automatic access_e decode_access(input logic enable, input logic rw_n,
                                            input logic [15:0] addr);
    decode_access = ACC_NONE;
    if (enable) begin
      if (rw_n && addr == JOY1_ADDR)       decode_access = ACC_RD_JOY1;
      else if (rw_n && addr == JOY2_ADDR)  decode_access = ACC_RD_JOY2;
      else if (!rw_n && addr == JOY1_ADDR) decode_access = ACC_WR_JOY1;
    end
  endfunction

endpackage

// File: rtl/nes_controller_port_if.sv
// nes_controller_port_if: CPU-side bus signals of the controller port.
//   ENABLE, ADDR, CPU_RW_n, DATA_IN : driven by the CPU (master)
//   DATA_OUT, DATA_OUT_valid        : driven by the port (slave)
interface nes_controller_port_if;
  logic        ENABLE;
  logic [15:0] ADDR;
  logic        CPU_RW_n;
  logic [7:0]  DATA_IN;
  logic [7:0]  DATA_OUT;
  logic        DATA_OUT_valid;

  modport master (
    output ENABLE, ADDR, CPU_RW_n, DATA_IN,
    input  DATA_OUT, DATA_OUT_valid
  );

  modport slave (
    input  ENABLE, ADDR, CPU_RW_n, DATA_IN,
    output DATA_OUT, DATA_OUT_valid
  );
endinterface

// File: rtl/nes_controller_port_keycode_to_buttons.sv
// keycode_to_buttons: combinational map from a USB HID usage code to a
// one-hot NES pad state. Unmapped codes (including 0) release all buttons.
//   keycode_i : HID usage code
//   buttons_o : one-hot button vector (bit order from nes_pkg)
module keycode_to_buttons
  import nes_pkg::*;
(
  input  logic [7:0] keycode_i,
  output logic [7:0] buttons_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives buttons_o (no latch).
    buttons_o = '0;
    case (keycode_i)
      KEY_A_BTN:      buttons_o[BTN_A]      = 1'b1;
      KEY_B_BTN:      buttons_o[BTN_B]      = 1'b1;
      KEY_SELECT_BTN: buttons_o[BTN_SELECT] = 1'b1;
      KEY_START_BTN:  buttons_o[BTN_START]  = 1'b1;
      KEY_UP_BTN:     buttons_o[BTN_UP]     = 1'b1;
      KEY_DOWN_BTN:   buttons_o[BTN_DOWN]   = 1'b1;
      KEY_LEFT_BTN:   buttons_o[BTN_LEFT]   = 1'b1;
      KEY_RIGHT_BTN:  buttons_o[BTN_RIGHT]  = 1'b1;
      default:        ;
    endcase
  end

endmodule

// File: rtl/nes_controller_port.sv
// nes_controller_port: NES standard controller at $4016, "no pad" at $4017.
// Debounces the USB keycode into a button state, latches it into a 4021-style
// shift register on strobe, and returns one bit per $4016 read.
//   CPU_CLK, RESET_n    : clock / async active-low reset
//   bus (slave)         : CPU enable, address, R/W, write data, read data/valid
//   controller_keycode  : HID usage code, already in CPU_CLK domain
//   buttons_debug       : debounced button state
module nes_controller_port
  import nes_pkg::*;
#(
  parameter int         KEY_STABLE_CYCLES = 2,
  parameter logic [7:0] OPEN_BUS          = 8'h40
) (
  input  logic                  CPU_CLK,
  input  logic                  RESET_n,
  nes_controller_port_if.slave  bus,
  input  logic [7:0]            controller_keycode,
  output logic [7:0]            buttons_debug
);

  localparam int            CW     = $clog2(KEY_STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE = CW'(KEY_STABLE_CYCLES);

  logic          strobe_q;
  logic [7:0]    shreg_q;
  logic [7:0]    buttons_q;
  logic [7:0]    cand_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    decoded;
  logic          load_buttons;
  logic          read_bit;
  access_e       acc;

  // Upper write-data bits have no function at $4016.
  logic unused_data_bits;
  assign unused_data_bits = ^bus.DATA_IN[7:1];

  keycode_to_buttons u_decode (
    .keycode_i (controller_keycode),
    .buttons_o (decoded)
  );

  assign acc = decode_access(bus.ENABLE, bus.CPU_RW_n, bus.ADDR);

  // Count consecutive enabled cycles the keycode has matched the candidate;
  // a new code counts as its first cycle. The count saturates at STABLE, and
  // buttons reload whenever the count stands at STABLE after this edge.
  always_comb begin
    if (controller_keycode != cand_q) cnt_d = CW'(1);
    else if (cnt_q == STABLE)         cnt_d = cnt_q;
    else                              cnt_d = cnt_q + CW'(1);
    load_buttons = (cnt_d == STABLE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CPU_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      strobe_q  <= 1'b0;
      shreg_q   <= 8'h00;
      buttons_q <= 8'h00;
      cand_q    <= 8'h00;
      cnt_q     <= '0;
    end else if (bus.ENABLE) begin
      cand_q <= controller_keycode;
      cnt_q  <= cnt_d;
      if (load_buttons) buttons_q <= decoded;
      if (acc == ACC_WR_JOY1) strobe_q <= bus.DATA_IN[0];
      // Strobe high keeps the register transparent; the value on the last
      // strobe-high cycle is what the CPU shifts out afterwards.
      if (strobe_q)                shreg_q <= buttons_q;
      else if (acc == ACC_RD_JOY1) shreg_q <= {1'b1, shreg_q[7:1]};
    end
  end

  assign read_bit = strobe_q ? buttons_q[0] : shreg_q[0];

  always_comb begin
    bus.DATA_OUT       = 8'h00;
    bus.DATA_OUT_valid = 1'b0;
    case (acc)
      ACC_RD_JOY1: begin
        bus.DATA_OUT       = {OPEN_BUS[7:1], read_bit};
        bus.DATA_OUT_valid = 1'b1;
      end
      ACC_RD_JOY2: begin
        bus.DATA_OUT       = {OPEN_BUS[7:1], 1'b0};
        bus.DATA_OUT_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign buttons_debug = buttons_q;

endmodule

// File: tb/tb_nes_controller_port.sv
// Self-checking bench for nes_controller_port: a directed vector table, hand
// sequences for strobe/debounce/reset corners, and a randomized run compared
// against a queue-based reference model.
module tb_nes_controller_port;
  import nes_pkg::*;

  localparam int K = 2;
  localparam logic [7:0] OB = 8'h40;

  logic       CPU_CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic [7:0] key     = 8'h00;
  logic [7:0] btn_dbg;

  nes_controller_port_if bus ();

  nes_controller_port #(.KEY_STABLE_CYCLES(K), .OPEN_BUS(OB)) dut (
    .CPU_CLK            (CPU_CLK),
    .RESET_n            (RESET_n),
    .bus                (bus),
    .controller_keycode (key),
    .buttons_debug      (btn_dbg)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [15:0] addr, input logic rw_n,
                       input logic [7:0] din);
    bus.ENABLE   = en;
    bus.ADDR     = addr;
    bus.CPU_RW_n = rw_n;
    bus.DATA_IN  = din;
  endtask

  // Drive one cycle, check the combinational read path, then take the edge.
  task automatic cyc(input string name, input logic en, input logic [15:0] addr,
                     input logic rw_n, input logic [7:0] din,
                     input logic [7:0] exp_do, input logic exp_v);
    drive(en, addr, rw_n, din);
    #1;
    check({name, " data"}, bus.DATA_OUT, exp_do);
    check({name, " valid"}, {7'd0, bus.DATA_OUT_valid}, {7'd0, exp_v});
    @(posedge CPU_CLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 16'h0000, 1'b1, 8'h00);
      @(posedge CPU_CLK); #1;
    end
  endtask

  task automatic rd1(input string name, input logic [7:0] exp);
    cyc(name, 1'b1, JOY1_ADDR, 1'b1, 8'h00, exp, 1'b1);
  endtask

  task automatic wr(input string name, input logic [15:0] addr, input logic [7:0] d);
    cyc(name, 1'b1, addr, 1'b0, d, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0000, 1'b1, 8'h00);
    RESET_n = 1'b0;
    repeat (2) @(posedge CPU_CLK);
    @(negedge CPU_CLK);
    RESET_n = 1'b1;
    @(posedge CPU_CLK); #1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] key_of [8] = '{8'h0E, 8'h0D, 8'h2B, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07};
  logic [7:0] m_btn, m_last;
  int         m_run;
  bit         m_strobe;
  bit         m_q[$];

  function automatic logic [7:0] ref_decode(input logic [7:0] k);
    for (int b = 0; b < 8; b++)
      if (k == key_of[b]) return 8'(1 << b);
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_btn = 8'h00; m_last = 8'h00; m_run = 0; m_strobe = 0;
    m_q.delete();
    for (int b = 0; b < 8; b++) m_q.push_back(1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        en;
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  din;
    logic [7:0]  key;
    logic [7:0]  exp_do;
    logic        exp_v;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic [15:0] addr, input logic rw_n,
                              input logic [7:0] din, input logic [7:0] k,
                              input logic [7:0] exp_do, input logic exp_v);
    vec_t v;
    v.en = en; v.addr = addr; v.rw_n = rw_n; v.din = din; v.key = k;
    v.exp_do = exp_do; v.exp_v = exp_v;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test plan 1 plus $4017 read and a disabled read in the middle of it.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 16'h0000, 1, 8'h00, 8'h0E, 8'h00, 0));
    tbl.push_back(mk(1, JOY1_ADDR, 0, 8'h01, 8'h0E, 8'h00, 0));
    tbl.push_back(mk(1, JOY1_ADDR, 0, 8'h00, 8'h0E, 8'h00, 0));
    tbl.push_back(mk(1, JOY1_ADDR, 1, 8'h00, 8'h0E, 8'h41, 1));
    tbl.push_back(mk(1, JOY2_ADDR, 1, 8'h00, 8'h0E, 8'h40, 1));
    tbl.push_back(mk(0, JOY1_ADDR, 1, 8'h00, 8'h0E, 8'h00, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(1, JOY1_ADDR, 1, 8'h00, 8'h0E, 8'h40, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, JOY1_ADDR, 1, 8'h00, 8'h0E, 8'h41, 1));
    tbl.push_back(mk(1, 16'h2002, 1, 8'h00, 8'h0E, 8'h00, 0));

    bus.ENABLE = 1'b0; bus.ADDR = '0; bus.CPU_RW_n = 1'b1; bus.DATA_IN = '0;
    do_reset();
    check("reset buttons", btn_dbg, 8'h00);

    foreach (tbl[i]) begin
      key = tbl[i].key;
      cyc($sformatf("vec%0d", i), tbl[i].en, tbl[i].addr, tbl[i].rw_n, tbl[i].din,
          tbl[i].exp_do, tbl[i].exp_v);
    end
    check("t1 buttons", btn_dbg, 8'h01);

    // Test 2: Right, with a disabled read that must not shift.
    key = 8'h07; idle(3);
    check("t2 buttons", btn_dbg, 8'h80);
    wr("t2 strobe1", JOY1_ADDR, 8'h01);
    wr("t2 strobe0", JOY1_ADDR, 8'h00);
    for (int i = 0; i < 3; i++) rd1($sformatf("t2 rd%0d", i), 8'h40);
    cyc("t2 disabled", 1'b0, JOY1_ADDR, 1'b1, 8'h00, 8'h00, 1'b0);
    for (int i = 3; i < 7; i++) rd1($sformatf("t2 rd%0d", i), 8'h40);
    rd1("t2 rd7", 8'h41);

    // Test 3: single-cycle keycode glitches do not reach the buttons.
    key = 8'h00; idle(3);
    check("t3 cleared", btn_dbg, 8'h00);
    key = 8'h1A; idle(1);
    key = 8'h00; idle(1);
    key = 8'h1A; idle(1);
    check("t3 glitch", btn_dbg, 8'h00);
    idle(1);
    check("t3 stable", btn_dbg, 8'h10);

    // Test 4: reads while strobe high never shift.
    key = 8'h0E; idle(3);
    wr("t4 strobe1", JOY1_ADDR, 8'h01);
    for (int i = 0; i < 5; i++) rd1($sformatf("t4 strobed rd%0d", i), 8'h41);
    wr("t4 strobe0", JOY1_ADDR, 8'h00);
    rd1("t4 rd0", 8'h41);
    rd1("t4 rd1", 8'h40);

    // Test 5: $4017 reads and writes leave $4016 alone.
    cyc("t5 rd4017", 1'b1, JOY2_ADDR, 1'b1, 8'h00, 8'h40, 1'b1);
    rd1("t5 rd2", 8'h40);
    wr("t5 wr4017", JOY2_ADDR, 8'hFF);
    rd1("t5 rd3", 8'h40);

    // Test 6: async reset in the middle of a read sequence.
    key = 8'h07; idle(3);
    wr("t6 strobe1", JOY1_ADDR, 8'h01);
    wr("t6 strobe0", JOY1_ADDR, 8'h00);
    key = 8'h0E;
    for (int i = 0; i < 3; i++) rd1($sformatf("t6 rd%0d", i), 8'h40);
    drive(1'b1, JOY1_ADDR, 1'b1, 8'h00);
    #2 RESET_n = 1'b0;
    #1;
    check("t6 reset buttons", btn_dbg, 8'h00);
    check("t6 reset data", bus.DATA_OUT, 8'h40);
    drive(1'b0, 16'h0000, 1'b1, 8'h00);
    @(negedge CPU_CLK); RESET_n = 1'b1;
    @(posedge CPU_CLK); #1;
    for (int i = 0; i < 8; i++) rd1($sformatf("t6 post rd%0d", i), 8'h40);
    rd1("t6 post rd8", 8'h41);

    // Randomized run against the reference model.
    key = 8'h00;
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic        en, rw_n, rd1_hit, rd2_hit, wr1_hit, bit0;
      logic [15:0] addr;
      logic [7:0]  din, exp_do, prev;
      int          r;
      en = ($urandom_range(0, 9) < 8);
      r  = $urandom_range(0, 19);
      addr = (r < 9) ? JOY1_ADDR : (r < 12) ? JOY2_ADDR : 16'($urandom);
      rw_n = ($urandom_range(0, 9) < 7);
      din  = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 9);
        key = (r < 8) ? key_of[r] : (r == 8) ? 8'h00 : 8'($urandom);
      end
      drive(en, addr, rw_n, din);
      #1;
      rd1_hit = en && rw_n && addr == 16'h4016;
      rd2_hit = en && rw_n && addr == 16'h4017;
      wr1_hit = en && !rw_n && addr == 16'h4016;
      bit0 = m_strobe ? m_btn[0] : (m_q.size() > 0 ? m_q[0] : 1'b1);
      exp_do = rd1_hit ? {7'h20, bit0} : rd2_hit ? 8'h40 : 8'h00;
      check($sformatf("rnd%0d data", n), bus.DATA_OUT, exp_do);
      check($sformatf("rnd%0d valid", n), {7'd0, bus.DATA_OUT_valid},
            {7'd0, rd1_hit | rd2_hit});
      check($sformatf("rnd%0d buttons", n), btn_dbg, m_btn);
      if (en) begin
        prev = m_btn;
        if (key == m_last) begin
          if (m_run < 1000) m_run++;
        end else begin
          m_last = key;
          m_run  = 1;
        end
        if (m_run >= K) m_btn = ref_decode(key);
        if (m_strobe) begin
          m_q.delete();
          for (int b = 0; b < 8; b++) m_q.push_back(prev[b]);
        end else if (rd1_hit && m_q.size() > 0) begin
          void'(m_q.pop_front());
        end
        if (wr1_hit) m_strobe = din[0];
      end
      @(posedge CPU_CLK); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
